// File: rtl/ptp_b.sv
// Parallel-to-parallel type B: emits a loaded word MSB-first as CHUNK_W-bit chunks or single bits.
// Optional parity output is enabled by defining PTP_B_PARITY_EN.
module ptp_b #(
    parameter int WORD_W  = 32,
    parameter int CHUNK_W = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic               serialise_i,
    input  logic [WORD_W-1:0]  value_i,
    input  logic               advance_i,
    output logic [CHUNK_W-1:0] value_o,
    output logic               valid_o,
    output logic               busy_o,
    output logic               done_o
`ifdef PTP_B_PARITY_EN
    ,
    output logic               parity_o
`endif
);

    localparam int CNT_W = $clog2(WORD_W) + 1;
    localparam logic [CNT_W-1:0] SER_CNT  = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] BYTE_CNT = CNT_W'(WORD_W / CHUNK_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q;
    logic [WORD_W-1:0]   shreg_q;
    logic [WORD_W-1:0]   shreg_d;
    logic [CNT_W-1:0]    remaining_q;
    logic                mode_q;
    logic                valid_q;
    logic                done_q;

    // Zero-filled left shift by one chunk or one bit, depending on the latched mode.
    always_comb begin
        shreg_d = mode_q ? (shreg_q << 1) : (shreg_q << CHUNK_W);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            remaining_q <= '0;
            mode_q      <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_i) begin
                        shreg_q     <= value_i;
                        mode_q      <= serialise_i;
                        remaining_q <= serialise_i ? SER_CNT : BYTE_CNT;
                        valid_q     <= 1'b1;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // load_i is deliberately ignored here so the word in flight is never disturbed.
                    if (advance_i) begin
                        shreg_q     <= shreg_d;
                        remaining_q <= remaining_q - LAST_CNT;
                        if (remaining_q == LAST_CNT) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        value_o = '0;
        if (valid_q) begin
            if (mode_q) begin
                value_o[0] = shreg_q[WORD_W-1];
            end else begin
                value_o = shreg_q[WORD_W-1 -: CHUNK_W];
            end
        end
    end

    assign valid_o = valid_q;
    assign busy_o  = valid_q;
    assign done_o  = done_q;

`ifdef PTP_B_PARITY_EN
    // value_o is forced to zero outside SHIFT, so parity is zero there as well.
    assign parity_o = ^value_o;
`endif

endmodule

// File: tb/tb_ptp_b.sv
// Directed bench for ptp_b: a queue of expected chunks is filled at load and drained as the DUT emits.
// Words are reassembled from the chunks to confirm the MSB-first round trip.
module tb_ptp_b;

    localparam int WORD_W  = 32;
    localparam int CHUNK_W = 8;

    logic               clk_i = 1'b0;
    logic               reset_i;
    logic               load_i;
    logic               serialise_i;
    logic [WORD_W-1:0]  value_i;
    logic               advance_i;
    logic [CHUNK_W-1:0] value_o;
    logic               valid_o;
    logic               busy_o;
    logic               done_o;
`ifdef PTP_B_PARITY_EN
    logic               parity_o;
`endif

    int checks   = 0;
    int failures = 0;
    logic [CHUNK_W-1:0] exp_q[$];

    ptp_b #(.WORD_W(WORD_W), .CHUNK_W(CHUNK_W)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (load_i),
        .serialise_i (serialise_i),
        .value_i     (value_i),
        .advance_i   (advance_i),
        .value_o     (value_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef PTP_B_PARITY_EN
        ,
        .parity_o    (parity_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_value"}, 32'(value_o), 32'h0);
        chk({tag, "_valid"}, 32'(valid_o), 32'h0);
        chk({tag, "_busy"},  32'(busy_o),  32'h0);
        chk({tag, "_done"},  32'(done_o),  32'h0);
`ifdef PTP_B_PARITY_EN
        chk({tag, "_parity"}, 32'(parity_o), 32'h0);
`endif
    endtask

    task automatic push_expected(input logic [WORD_W-1:0] word, input logic ser);
        int n;
        logic [CHUNK_W-1:0] c;
        n = ser ? WORD_W : WORD_W / CHUNK_W;
        for (int i = 0; i < n; i++) begin
            c = '0;
            if (ser) c[0] = word[WORD_W-1-i];
            else     c = word[WORD_W-1-CHUNK_W*i -: CHUNK_W];
            exp_q.push_back(c);
        end
    endtask

    // One complete transfer; optionally advance in the load cycle and/or hold load_i=1 with a zero word throughout.
    task automatic run_transfer(input logic [WORD_W-1:0] word, input logic ser,
                                input logic adv_on_load, input logic inject_load);
        logic [WORD_W-1:0]  rb;
        logic [CHUNK_W-1:0] e;
        int n;
        n = ser ? WORD_W : WORD_W / CHUNK_W;
        push_expected(word, ser);
        value_i     = word;
        serialise_i = ser;
        load_i      = 1'b1;
        advance_i   = adv_on_load;
        step();
        load_i      = 1'b0;
        advance_i   = 1'b0;
        value_i     = $urandom;
        serialise_i = ~ser;
        rb = '0;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                chk("queue_underflow", 32'(exp_q.size()), 32'h1);
                break;
            end
            e = exp_q.pop_front();
            chk("valid", 32'(valid_o), 32'h1);
            chk("busy",  32'(busy_o),  32'h1);
            chk("done_early", 32'(done_o), 32'h0);
            chk(ser ? "bit" : "chunk", 32'(value_o), 32'(e));
`ifdef PTP_B_PARITY_EN
            chk("parity", 32'(parity_o), 32'(^e));
`endif
            rb = ser ? {rb[WORD_W-2:0], value_o[0]} : {rb[WORD_W-CHUNK_W-1:0], value_o};
            advance_i = 1'b1;
            if (inject_load) begin
                load_i  = 1'b1;
                value_i = '0;
            end
            step();
            advance_i = 1'b0;
            load_i    = 1'b0;
        end
        chk("done_pulse",  32'(done_o),  32'h1);
        chk("valid_after", 32'(valid_o), 32'h0);
        chk("roundtrip",   rb,           word);
        step();
        check_idle("post_done");
    endtask

    initial begin
        reset_i     = 1'b1;
        load_i      = 1'b0;
        serialise_i = 1'b0;
        value_i     = '0;
        advance_i   = 1'b0;
        #2;
        check_idle("reset");
        step();
        step();
        reset_i = 1'b0;
        step();
        check_idle("after_reset");

        // Byte and serial basics
        run_transfer(32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        run_transfer(32'h80000001, 1'b1, 1'b0, 1'b0);

        // Round trips in both modes
        run_transfer(32'h12345678, 1'b0, 1'b0, 1'b0);
        run_transfer(32'h12345678, 1'b1, 1'b0, 1'b0);
        run_transfer(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        run_transfer(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);

        // load_i held with a zero word during the whole transfer must be ignored
        run_transfer(32'hA5A5A5A5, 1'b0, 1'b0, 1'b1);

        // advance_i in IDLE does nothing
        advance_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("idle_adv");
        end
        advance_i = 1'b0;

        // load and advance together: the advance is dropped, first chunk not skipped
        run_transfer(32'hA5123456, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset after two of four byte advances
        push_expected(32'h11223344, 1'b0);
        value_i     = 32'h11223344;
        serialise_i = 1'b0;
        load_i      = 1'b1;
        step();
        load_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("pre_reset_chunk", 32'(value_o), 32'(exp_q.pop_front()));
            advance_i = 1'b1;
            step();
            advance_i = 1'b0;
        end
        chk("pre_reset_chunk3", 32'(value_o), 32'(exp_q[0]));
        reset_i = 1'b1;
        #1;
        check_idle("async_reset");
        exp_q.delete();
        step();
        check_idle("in_reset");
        reset_i = 1'b0;
        step();
        check_idle("reset_release");
        step();
        check_idle("reset_no_done");
        run_transfer(32'h01020304, 1'b0, 1'b0, 1'b0);

        // Parity-oriented chunks 07, 03 (also exercised without the parity port)
        run_transfer(32'h07030000, 1'b0, 1'b0, 1'b0);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
